// File: rtl/mole_pkg.sv
// mole_pkg: shared state encoding and mole index selection for the whack-a-mole sequencer
package mole_pkg;
  localparam int MOLE_IDX_W = 3;
  typedef enum logic [2:0] {IDLE, GAP, REQ, WAIT, SHOW, DONE} state_e;
  typedef logic [MOLE_IDX_W:0] pidx_t;
  function automatic pidx_t pick_mole(input logic [MOLE_IDX_W-1:0] rnd, input pidx_t prev, input int n);
    pidx_t v;
    pidx_t m;
    m = pidx_t'(n);
    v = {1'b0, rnd};
    v = (v >= m) ? v - m : v;
    if (v == prev) v = (v + pidx_t'(1) == m) ? '0 : v + pidx_t'(1);
    return v;
  endfunction
endpackage

// File: rtl/mole_scheduler_if.sv
// mole_scheduler_if: timebase, button, random-block and display signals of the sequencer
interface mole_scheduler_if #(
  parameter int NUM_MOLES = 5,
  parameter int SCORE_W = 8
);
  logic tick;
  logic start;
  logic [NUM_MOLES-1:0] btn_pulse;
  logic [2:0] rnd_num;
  logic rnd_en;
  logic [NUM_MOLES-1:0] mole_on;
  logic [SCORE_W-1:0] score;
  logic [SCORE_W-1:0] misses;
  logic [SCORE_W-1:0] round_cnt;
  logic busy;
  logic done;
  modport master (
    output tick, start, btn_pulse, rnd_num,
    input rnd_en, mole_on, score, misses, round_cnt, busy, done
  );
  modport slave (
    input tick, start, btn_pulse, rnd_num,
    output rnd_en, mole_on, score, misses, round_cnt, busy, done
  );
endinterface

// File: rtl/tick_timer.sv
// tick_timer: loadable down-counter that expires on the tick that takes it from 1 to 0
module tick_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         tick,
  output logic         expire
);
  logic [W-1:0] timer_q, timer_d;
  assign expire = tick && (timer_q == W'(1));
  always_comb timer_d = load ? load_val : (tick && timer_q != '0) ? timer_q - W'(1) : timer_q;
  always_ff @(posedge clk) timer_q <= !rst_n ? '0 : timer_d;
endmodule

// File: rtl/mole_scheduler.sv
// mole_scheduler: lights one random mole per round, judges presses and keeps score
module mole_scheduler
  import mole_pkg::*;
#(
  parameter int NUM_MOLES = 5,
  parameter int UP_TICKS  = 50,
  parameter int GAP_TICKS = 10,
  parameter int ROUNDS    = 30,
  parameter int SCORE_W   = 8
) (
  input logic clk,
  input logic rst_n,
  mole_scheduler_if.slave bus
);
  localparam int TMAX = (UP_TICKS > GAP_TICKS) ? UP_TICKS : GAP_TICKS;
  localparam int TW = $clog2(TMAX + 1);
  state_e state_q, state_d, fin;
  logic [SCORE_W-1:0] score_q, score_d, misses_q, misses_d, round_q, round_d, round_inc;
  logic [NUM_MOLES-1:0] mole_on_q, mole_on_d;
  pidx_t prev_q, prev_d, pick;
  logic rnd_en_q, done_q, hit, wrong, t_load, expire;
  logic [TW-1:0] t_val;
  function automatic logic [SCORE_W-1:0] sat_inc(input logic [SCORE_W-1:0] v);
    return &v ? v : v + SCORE_W'(1);
  endfunction
  tick_timer #(.W(TW)) u_timer (
    .clk(clk), .rst_n(rst_n), .load(t_load), .load_val(t_val), .tick(bus.tick), .expire(expire)
  );
  always_comb begin
    state_d = state_q;
    score_d = score_q;
    misses_d = misses_q;
    round_d = round_q;
    mole_on_d = mole_on_q;
    prev_d = prev_q;
    t_load = 1'b0;
    t_val = TW'(GAP_TICKS);
    hit = |(bus.btn_pulse & mole_on_q);
    wrong = |(bus.btn_pulse & ~mole_on_q);
    round_inc = round_q + SCORE_W'(1);
    fin = (round_inc == SCORE_W'(ROUNDS)) ? DONE : GAP;
    pick = pick_mole(bus.rnd_num, prev_q, NUM_MOLES);
    case (state_q)
      IDLE, DONE: if (bus.start) begin
        score_d = '0;
        misses_d = '0;
        round_d = '0;
        t_load = 1'b1;
        state_d = GAP;
      end
      GAP: state_d = expire ? REQ : GAP;
      REQ: state_d = WAIT;
      WAIT: begin
        prev_d = pick;
        mole_on_d = NUM_MOLES'(1) << pick;
        t_load = 1'b1;
        t_val = TW'(UP_TICKS);
        state_d = SHOW;
      end
      SHOW: if (hit || expire) begin
        // a correct press beats a simultaneous timeout or stray buttons
        score_d = hit ? sat_inc(score_q) : score_q;
        misses_d = hit ? misses_q : sat_inc(misses_q);
        round_d = round_inc;
        mole_on_d = '0;
        t_load = (fin == GAP);
        state_d = fin;
      end else if (wrong) begin
        misses_d = sat_inc(misses_q);
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      score_q <= '0;
      misses_q <= '0;
      round_q <= '0;
      mole_on_q <= '0;
      prev_q <= pidx_t'(NUM_MOLES);
      rnd_en_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      score_q <= score_d;
      misses_q <= misses_d;
      round_q <= round_d;
      mole_on_q <= mole_on_d;
      prev_q <= prev_d;
      rnd_en_q <= (state_d == REQ);
      done_q <= (state_d == DONE);
    end
  end
  assign bus.rnd_en = rnd_en_q;
  assign bus.mole_on = mole_on_q;
  assign bus.score = score_q;
  assign bus.misses = misses_q;
  assign bus.round_cnt = round_q;
  assign bus.done = done_q;
  assign bus.busy = (state_q != IDLE) && (state_q != DONE);
endmodule

// File: doc/mole_scheduler.md
Name: mole_scheduler

Overview:
Game sequencer for the whack-a-mole datapath. It requests indices from the LFSR random block (`rnd_en` / `rnd_num`) and lights one mole at a time for a fixed window. It judges player button pulses, keeps score, miss and round counts, and ends the game after ROUNDS moles. It sits between the random block, the debounced button front-end, and the LED/display drivers.

Parameters:
NUM_MOLES, 5, number of moles/buttons (2..8; index fits 3 bits)
UP_TICKS, 50, mole visible window in `tick` periods (>=1)
GAP_TICKS, 10, dark interval between moles in `tick` periods (>=1)
ROUNDS, 30, moles per game (>=1)
SCORE_W, 8, width of score/misses/round counters

Ports:
clk  in  1  system clock
rst_n  in  1  synchronous active-low reset; all state is cleared on a clk edge while low
tick  in  1  one-cycle timebase pulse (e.g. 10 ms)
start  in  1  one-cycle pulse; starts or restarts a game from IDLE/DONE
btn_pulse  in  NUM_MOLES  debounced one-cycle button pulses, bit i = mole i
rnd_num  in  3  random index from random block
rnd_en  out  1  one-cycle request to random block
mole_on  out  NUM_MOLES  one-hot lit mole, 0 when dark
score  out  SCORE_W  correct hits, saturating
misses  out  SCORE_W  wrong presses plus timeouts, saturating
round_cnt  out  SCORE_W  moles completed this game
busy  out  1  high in any state except IDLE and DONE
done  out  1  high in DONE

Behaviour:
- Reset (`rst_n` low at a clk edge): state=IDLE; all outputs 0; `timer`=0; `prev_idx`=NUM_MOLES (invalid). Reset mid-game aborts immediately; `rnd_en` is never left high.
- Timer: loaded with N, decrements on `tick`. It expires on a cycle with `tick`=1 and `timer`==1, so the window is N ticks (first tick may be partial).
- States:
  - IDLE: on `start`, clear score/misses/round_cnt, load timer=GAP_TICKS, go to GAP.
  - GAP: all moles dark; buttons ignored. On expiry go to REQ.
  - REQ: `rnd_en`=1 for exactly this cycle; go to WAIT.
  - WAIT: the random block updates on the edge ending REQ, so `rnd_num` is sampled in WAIT.
    - Fold: v = `rnd_num` >= NUM_MOLES ? `rnd_num` - NUM_MOLES : `rnd_num`.
    - If v == `prev_idx`, v = (v+1) mod NUM_MOLES.
    - Set `mole_idx`=`prev_idx`=v; `mole_on` = 1<<v on the next cycle; load timer=UP_TICKS; go to SHOW.
    - Latency from REQ cycle to `mole_on` visible = 2 cycles.
  - SHOW, correct hit (`btn_pulse`[`mole_idx`]=1): score+1, clear `mole_on`, round_cnt+1, then go to GAP (reload GAP_TICKS), or to DONE if the new round_cnt==ROUNDS.
  - SHOW, wrong press (any other bit set, correct bit clear): misses+1 once per cycle regardless of how many bits are set; mole stays lit, timer continues.
  - SHOW, expiry: misses+1, clear `mole_on`, round_cnt+1, same next-state rule as a correct hit.
  - DONE: counters held; `done`=1; on `start`, behave as IDLE+`start` (clear and go to GAP).
- Simultaneous events in SHOW:
  - Correct hit plus expiry in the same cycle: the hit wins; misses unchanged.
  - Correct plus wrong bits in the same cycle: only the hit counts.
- `start` while `busy`: ignored.
- Arithmetic: score and misses saturate at 2^SCORE_W-1.
- Register outputs: `mole_on`, score, misses, round_cnt, `done` and `rnd_en` are registered; `busy` is decoded from state.

Decomposition:
- Shared package `mole_pkg`:
  - state encoding: IDLE, GAP, REQ, WAIT, SHOW, DONE (3 bits);
  - MOLE_IDX_W=3;
  - fold/no-repeat function.
- Sub-module `tick_timer`: loadable down-counter with `load`, `load_val`, `tick` and `expire` outputs. It is instantiated once and shared by GAP and SHOW.

Test Plan:
- Common parameters: UP_TICKS=4, GAP_TICKS=2, ROUNDS=3, `tick` every 4 clk.
- Reset/idle: hold `rst_n`=0 for 3 clk, release -> all outputs 0, `busy`=0, `rnd_en` never asserted until `start`.
- Request timing: `start`; after 2 ticks `rnd_en` is high for 1 cycle; force `rnd_num`=6 -> exactly 2 cycles after REQ, `mole_on`=5'b00010 (6-5=1).
- Hit and no-repeat:
  - Pulse `btn_pulse`[1] while lit -> score=1, `mole_on`=0 next cycle, round_cnt=1.
  - Next draw `rnd_num`=1 -> `mole_on`=5'b00100.
- Wrong then timeout: press bit 0 twice while mole 2 is lit, then no hit -> misses=2 after presses, misses=3 and round_cnt=2 after 4 ticks.
- Simultaneous and finish:
  - Correct press on the same cycle as expiry -> score+1, misses unchanged.
  - round_cnt reaches 3 -> `done`=1, `busy`=0.
  - Pulse `start` -> counters clear, GAP entered.
- Mid-game reset and saturation:
  - Assert `rst_n`=0 during SHOW -> next cycle all zero, IDLE.
  - With SCORE_W=2, 5 wrong presses -> misses stays 3.
